// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: configuration strobe/fields, qualified
// serial data in, match pulse and fill level out.
// Optional feature macro: MATCH_CNT_EN (adds the 16-bit match_cnt signal).
interface seq_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             in_valid;
    logic             in;
    logic             match;
    logic [LEN_W-1:0] fill;
`ifdef MATCH_CNT_EN
    logic [15:0]      match_cnt;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
        input  match, fill, match_cnt
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
        output match, fill, match_cnt
    );
`else
    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
        input  match, fill
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
        output match, fill
    );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlapping and
// non-overlapping modes and a registered one-cycle match pulse.
// Optional feature macro: MATCH_CNT_EN (saturating 16-bit hit counter).
//
// state | meaning
// IDLE  | fewer than len valid bits collected since the last clear
// ARMED | at least len valid bits collected; the next valid bit can match
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    seq_detector_param_if.slave bus
);
    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic             match_r;

    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [LEN_W-1:0] len_clamp;
    logic [PAT_W-1:0] mask;
    logic             armed_n;
    logic             hit;

    // Next-sample history, saturating fill, compare mask and the hit decision.
    // Once ARMED the fill can only grow, so the state alone proves fill_n >= len.
    always_comb begin
        hist_n    = {hist[PAT_W-2:0], bus.in};
        fill_n    = (fill >= LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
        len_clamp = (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(PAT_W))
                    ? LEN_W'(PAT_W) : bus.cfg_len;
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        armed_n = (state == ARMED) || (fill_n >= len);
        hit     = bus.in_valid && armed_n && (((hist_n ^ pattern) & mask) == '0);
    end

    // Config, history shift, IDLE/ARMED tracking and the registered match pulse.
    // Config beats a same-cycle data bit; a non-overlapping hit restarts from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern <= '0;
            len     <= LEN_W'(1);
            overlap <= 1'b1;
            hist    <= '0;
            fill    <= '0;
            match_r <= 1'b0;
            state   <= IDLE;
        end else if (bus.cfg_load) begin
            pattern <= bus.cfg_pattern;
            len     <= len_clamp;
            overlap <= bus.cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            match_r <= 1'b0;
            state   <= IDLE;
        end else if (bus.in_valid) begin
            match_r <= hit;
            if (hit && !overlap) begin
                hist  <= '0;
                fill  <= '0;
                state <= IDLE;
            end else begin
                hist  <= hist_n;
                fill  <= fill_n;
                state <= armed_n ? ARMED : IDLE;
            end
        end else begin
            match_r <= 1'b0;
        end
    end

    assign bus.match = match_r;
    assign bus.fill  = fill;

`ifdef MATCH_CNT_EN
    logic [15:0] match_cnt;

    // Saturating hit counter; a config load discards any same-cycle hit.
    always_ff @(posedge clk) begin
        if (reset || bus.cfg_load) begin
            match_cnt <= '0;
        end else if (hit && match_cnt != 16'hFFFF) begin
            match_cnt <= match_cnt + 16'd1;
        end
    end

    assign bus.match_cnt = match_cnt;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W = 8): a vector table for the
// short scenarios plus hand-written loops for the 8-bit pattern cases.
module tb_seq_detector_param;
    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef struct {
        logic             rst;
        logic             ld;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ov;
        logic             v;
        logic             b;
        logic             m;
        logic [LEN_W-1:0] f;
        logic [15:0]      c;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    seq_detector_param_if #(.PAT_W(PAT_W)) bus ();

    seq_detector_param #(.PAT_W(PAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(logic rst, logic ld, logic [PAT_W-1:0] pat,
                                logic [LEN_W-1:0] len, logic ov, logic v, logic b,
                                logic m, logic [LEN_W-1:0] f, logic [15:0] c);
        vec_t x;
        x.rst = rst; x.ld = ld; x.pat = pat; x.len = len; x.ov = ov;
        x.v = v; x.b = b; x.m = m; x.f = f; x.c = c;
        vecs.push_back(x);
    endfunction

    task automatic apply(logic rst, logic ld, logic [PAT_W-1:0] pat,
                         logic [LEN_W-1:0] len, logic ov, logic v, logic b);
        @(negedge clk);
        reset           = rst;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.in_valid    = v;
        bus.in          = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic m, logic [LEN_W-1:0] f, logic [15:0] c);
        vectors++;
        if (bus.match !== m || bus.fill !== f) begin
            miscompares++;
            $display("FAIL %s: got match=%0b fill=%0d, expected match=%0b fill=%0d",
                     name, bus.match, bus.fill, m, f);
        end
`ifdef MATCH_CNT_EN
        if (bus.match_cnt !== c) begin
            miscompares++;
            $display("FAIL %s cnt: got match_cnt=%0d, expected %0d", name, bus.match_cnt, c);
        end
`else
        if (c > 16'hFFFF) $display("unreachable");
`endif
    endtask

    initial begin
        logic [7:0]       a5;
        logic [LEN_W-1:0] lens[3];
        logic             em;
        logic [LEN_W-1:0] ef;
        logic [15:0]      ec;

        bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_overlap = 1'b0; bus.in_valid = 1'b0; bus.in = 1'b0;

        // reset defaults: pattern 0, len 1, overlap on -> every valid 0 matches
        add(1,0,8'h00,0,0,0,0, 0,0,0);
        add(0,0,8'h00,0,0,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,0, 1,1,1);
        add(0,0,8'h00,0,0,1,1, 0,2,1);
        add(0,0,8'h00,0,0,1,0, 1,3,2);
        // 110 len 3 overlap: 1,1,0,0,1,1,0 then two more to saturate fill
        add(0,1,8'b110,3,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,1, 0,2,0);
        add(0,0,8'h00,0,0,1,0, 1,3,1);
        add(0,0,8'h00,0,0,1,0, 0,4,1);
        add(0,0,8'h00,0,0,1,1, 0,5,1);
        add(0,0,8'h00,0,0,1,1, 0,6,1);
        add(0,0,8'h00,0,0,1,0, 1,7,2);
        add(0,0,8'h00,0,0,1,1, 0,8,2);
        add(0,0,8'h00,0,0,1,0, 0,8,2);
        // 101 overlapping: two matches
        add(0,1,8'b101,3,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,0, 0,2,0);
        add(0,0,8'h00,0,0,1,1, 1,3,1);
        add(0,0,8'h00,0,0,1,0, 0,4,1);
        add(0,0,8'h00,0,0,1,1, 1,5,2);
        // 101 non-overlapping: one match, history cleared on the hit
        add(0,1,8'b101,3,0,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,0, 0,2,0);
        add(0,0,8'h00,0,0,1,1, 1,0,1);
        add(0,0,8'h00,0,0,1,0, 0,1,1);
        add(0,0,8'h00,0,0,1,1, 0,2,1);
        // 1011 with a 3-cycle valid gap between bits 2 and 3
        add(0,1,8'b1011,4,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,0, 0,2,0);
        add(0,0,8'h00,0,0,0,1, 0,2,0);
        add(0,0,8'h00,0,0,0,1, 0,2,0);
        add(0,0,8'h00,0,0,0,1, 0,2,0);
        add(0,0,8'h00,0,0,1,1, 0,3,0);
        add(0,0,8'h00,0,0,1,1, 1,4,1);
        add(0,0,8'h00,0,0,0,0, 0,4,1);
        // cfg_load with a completing data bit: config wins, bit discarded
        add(0,1,8'b110,3,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,1, 0,2,0);
        add(0,1,8'b110,3,1,1,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,1, 0,2,0);
        add(0,0,8'h00,0,0,1,0, 1,3,1);
        // reset mid-pattern (with a completing bit present), then a fresh run
        add(0,1,8'b110,3,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,1, 0,1,0);
        add(0,0,8'h00,0,0,1,1, 0,2,0);
        add(1,0,8'h00,0,0,1,0, 0,0,0);
        add(0,1,8'b110,3,1,0,0, 0,0,0);
        add(0,0,8'h00,0,0,1,0, 0,1,0);
        add(0,0,8'h00,0,0,1,1, 0,2,0);
        add(0,0,8'h00,0,0,1,1, 0,3,0);
        add(0,0,8'h00,0,0,1,0, 1,4,1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].ld, vecs[i].pat, vecs[i].len,
                  vecs[i].ov, vecs[i].v, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].m, vecs[i].f, vecs[i].c);
        end

        // 0xA5, len 8 / 0 / 12 (both clamp to 8), non-overlapping, two copies
        a5 = 8'hA5;
        lens[0] = 4'd8; lens[1] = 4'd0; lens[2] = 4'd12;
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 8'hA5, lens[k], 0, 0, 0);
            check($sformatf("a5_load_len%0d", lens[k]), 0, 0, 0);
            for (int i = 0; i < 16; i++) begin
                apply(0, 0, 8'h00, 0, 0, 1, a5[7 - (i % 8)]);
                em = (i == 7 || i == 15);
                ef = (i % 8 == 7) ? 4'd0 : LEN_W'(i % 8 + 1);
                ec = (i >= 15) ? 16'd2 : (i >= 7) ? 16'd1 : 16'd0;
                check($sformatf("a5_len%0d_bit%0d", lens[k], i + 1), em, ef, ec);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
